bt656_line_writer: RTL and testbench
====================================

// Module: bt656_line_writer
// PURPOSE
//  Write-side sequencer for the 5-line FIFO (720-entry lines) on clock_in.
//  Parses the BT.656 byte stream for TRS codes (FF 00 00 XY) and tracks field/vblank.
//  Extracts the 720 luma (Y) samples of each active line and drives the FIFO write port.
//  Every line written is exactly SAMPLES_PER_LINE long, so the FIFO's line pointer stays aligned.
// PARAMETERS
//  SAMPLES_PER_LINE  720    Y samples per line; must equal the FIFO line size
//  PAD_VALUE         8'h10  black-level Y value used to pad short lines
// PORTS
//  clock_in      in   1   27 MHz BT.656 byte clock
//  reset         in   1   asynchronous, active-high
//  bt_data       in   8   BT.656 byte stream, one byte per clock
//  fifo_full     in   1   FIFO full flag; sampled only at SAV
//  fifo_data     out  8   FIFO write data
//  fifo_write    out  1   FIFO write strobe, one sample per cycle
//  field         out  1   F bit of the last TRS
//  vblank        out  1   V bit of the last TRS
//  line_done     out  1   1-cycle pulse after the last write of a line
//  line_dropped  out  1   1-cycle pulse when an active line is skipped
//  sync_error    out  1   1-cycle pulse when a line ends before SAMPLES_PER_LINE Y samples
//  drop_count    out  16  dropped-line counter (BT656_LW_STATS_EN only)
//  line_count    out  16  completed-line counter (BT656_LW_STATS_EN only)
// BEHAVIOUR
//  Reset values:
//   - fifo_write, line_done, line_dropped, sync_error, field, fifo_data, counters = 0
//   - vblank = 1; state = WAIT_SAV
//   - Reset mid-line aborts the line immediately. The FIFO shares reset, so its pointers clear too.
//  Byte pipeline:
//   - 4-stage shift register s0 (newest) .. s3.
//   - TRS = s3==FF && s2==00 && s1==00 && s0[7]==1. XY = s0: F=bit6, V=bit5, H=bit4 (1=EAV, 0=SAV).
//   - Protection bits [3:0] are ignored.
//   - TRS preamble bytes are never written.
//   - Latency: a Y byte on bt_data at cycle N produces fifo_write/fifo_data at cycle N+4 (registered).
//  Field/vblank: field<=F and vblank<=V on every TRS.
//  Byte phase: counter reset at SAV; the byte after XY is phase 0. Order is Cb,Y,Cr,Y; Y = odd phases.
//  States:
//   WAIT_SAV:
//    - SAV with V=0 and fifo_full=0 -> ACTIVE, sample count = 0.
//    - SAV with V=0 and fifo_full=1 -> DROP, line_dropped pulse.
//    - SAV with V=1 -> stays in WAIT_SAV; no writes.
//   ACTIVE:
//    - Each Y byte: fifo_write=1, fifo_data=Y, count+1.
//    - On count == SAMPLES_PER_LINE-1 write -> line_done next cycle -> WAIT_SAV.
//    - Extra Y bytes after that are ignored with no error.
//    - TRS (EAV or SAV) with count < SAMPLES_PER_LINE -> sync_error pulse -> PAD.
//   PAD:
//    - Writes PAD_VALUE every cycle until count == SAMPLES_PER_LINE, then line_done -> WAIT_SAV.
//    - TRS tracking continues during PAD. A SAV seen during PAD drops that line (line_dropped pulse).
//   DROP: no writes; the next EAV -> WAIT_SAV.
//  fifo_full:
//   - Checked only at SAV.
//   - Mid-line it can only fall (the FIFO head advances only at line end), so ACTIVE writes are never blocked.
//  Count width: clog2(SAMPLES_PER_LINE). The count is never exceeded; no wrap inside a line.
//  Simultaneous events: line_done and line_dropped may pulse in the same cycle.
// CONFIGURATION
//  BT656_LW_STATS_EN defined:
//   - drop_count and line_count exist. They increment on line_dropped / line_done.
//   - They saturate at 16'hFFFF and clear only on reset.
//  BT656_LW_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. SAV(V=0), 720 Y ramp 0x20.. (Cb/Cr=0x80), EAV -> exactly 720 writes of the ramp; first write 4 cycles after the first Y byte; line_done after the last write.
//  2. fifo_full=1 at SAV -> 0 writes, line_dropped=1 for 1 cycle; next line with full=0 -> 720 writes.
//  3. EAV after 700 Y -> 700 data writes, sync_error pulse, 20 writes of 0x10, line_done; total 720.
//  4. SAV with V=1, F=1 -> vblank=1, field=1, no fifo_write for the whole line.
//  5. Assert reset after 300 writes -> fifo_write=0 at once, vblank=1; next active line -> 720 writes.
//  6. With BT656_LW_STATS_EN: 3 lines complete, 2 dropped -> line_count=3, drop_count=2.

Source files
------------

// File: rtl/bt656_line_writer.sv
// -----------------------------------------------------------------------------
// bt656_line_writer
//   Write-side sequencer for a 5-line luma FIFO fed from a BT.656 byte stream.
//   Finds TRS codes (FF 00 00 XY), tracks field/vblank, extracts the Y samples
//   of each active line and writes exactly SAMPLES_PER_LINE samples per line.
//   A line is padded with PAD_VALUE when it ends early, so the FIFO's line
//   pointer never drifts.
//
//   Optional feature macro: BT656_LW_STATS_EN
//     When defined, the drop_count and line_count ports and their counters exist.
//
// Ports
//   clock_in      in   27 MHz BT.656 byte clock
//   reset         in   asynchronous, active-high reset
//   bt_data       in   BT.656 byte stream, one byte per clock
//   fifo_full     in   FIFO full flag, only looked at when a SAV arrives
//   fifo_data     out  FIFO write data (registered)
//   fifo_write    out  FIFO write strobe (registered)
//   field         out  F bit of the most recent TRS
//   vblank        out  V bit of the most recent TRS
//   line_done     out  1-cycle pulse the cycle after the last write of a line
//   line_dropped  out  1-cycle pulse when an active line is skipped
//   drop_count    out  saturating dropped-line counter (BT656_LW_STATS_EN)
//   line_count    out  saturating completed-line counter (BT656_LW_STATS_EN)
//   sync_error    out  1-cycle pulse when a line ends short of SAMPLES_PER_LINE
// -----------------------------------------------------------------------------
module bt656_line_writer #(
   parameter int unsigned SAMPLES_PER_LINE = 720,
   parameter logic [7:0]  PAD_VALUE        = 8'h10
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [7:0]  bt_data,
   input  logic        fifo_full,
   output logic [7:0]  fifo_data,
   output logic        fifo_write,
   output logic        field,
   output logic        vblank,
   output logic        line_done,
   output logic        line_dropped,
`ifdef BT656_LW_STATS_EN
   output logic [15:0] drop_count,
   output logic [15:0] line_count,
`endif
   output logic        sync_error
);

   localparam int unsigned    CW       = $clog2(SAMPLES_PER_LINE);
   localparam logic [CW-1:0]  LAST_CNT = CW'(SAMPLES_PER_LINE - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      WAIT_SAV = 2'd0,
      ACTIVE   = 2'd1,
      PAD      = 2'd2,
      DROP     = 2'd3
   } state_t;

   // byte pipeline, s0 newest
   logic [7:0]    s0_q, s1_q, s2_q, s3_q;
   // phase_odd_q is the Cb/Y parity of the byte currently in s0
   logic          phase_odd_q, phase_odd_d;
   logic          in_line_q, in_line_d;
   // Y tags travelling alongside s1/s2
   logic          tag1_q, tag1_d, tag2_q, tag2_d;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          fifo_write_q, fifo_write_d;
   logic [7:0]    fifo_data_q, fifo_data_d;
   logic          last_q, last_d;
   logic          line_done_q;
   logic          line_dropped_q, line_dropped_d;
   logic          sync_error_q, sync_error_d;
   logic          field_q, vblank_q;

   logic          trs_s, sav_s, eav_s, xy_v_s, pre_trs_s, tag0_s, y_byte_s;

   assign trs_s  = (s3_q == 8'hFF) && (s2_q == 8'h00) && (s1_q == 8'h00) && s0_q[7];
   assign sav_s  = trs_s && !s0_q[4];
   assign eav_s  = trs_s &&  s0_q[4];
   assign xy_v_s = s0_q[5];
   // s2 holding FF followed by 00 00 is the start of a preamble, never a sample
   assign pre_trs_s = (s2_q == 8'hFF) && (s1_q == 8'h00) && (s0_q == 8'h00);
   assign tag0_s    = in_line_q && phase_odd_q;
   // Y is taken from s2 so the preamble is visible in s1/s0 before it could be written
   assign y_byte_s  = tag2_q && !pre_trs_s;

   // Phase parity, line window and Y-tag next state
   always_comb begin
      phase_odd_d = ~phase_odd_q;
      in_line_d   = in_line_q;
      tag1_d      = tag0_s;
      tag2_d      = tag1_q;
      if (trs_s) begin
         // the byte after XY is phase 0; bytes already in flight are preamble
         phase_odd_d = 1'b0;
         in_line_d   = !s0_q[4];
         tag1_d      = 1'b0;
         tag2_d      = 1'b0;
      end else begin
         in_line_d   = in_line_q;
      end
   end

   // Byte shift register, phase parity and Y tags
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         s0_q        <= 8'h00;
         s1_q        <= 8'h00;
         s2_q        <= 8'h00;
         s3_q        <= 8'h00;
         phase_odd_q <= 1'b0;
         in_line_q   <= 1'b0;
         tag1_q      <= 1'b0;
         tag2_q      <= 1'b0;
      end else begin
         s0_q        <= bt_data;
         s1_q        <= s0_q;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         phase_odd_q <= phase_odd_d;
         in_line_q   <= in_line_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag2_d;
      end
   end

   // Field and vblank follow every TRS
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         field_q  <= 1'b0;
         vblank_q <= 1'b1;
      end else if (trs_s) begin
         field_q  <= s0_q[6];
         vblank_q <= s0_q[5];
      end
   end

   // Line FSM: next state, sample count and write/pulse outputs
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      fifo_write_d   = 1'b0;
      fifo_data_d    = fifo_data_q;
      last_d         = 1'b0;
      line_dropped_d = 1'b0;
      sync_error_d   = 1'b0;
      case (state_q)
         WAIT_SAV: begin
            if (sav_s && !xy_v_s) begin
               if (fifo_full) begin
                  state_d        = DROP;
                  line_dropped_d = 1'b1;
               end else begin
                  state_d = ACTIVE;
                  count_d = CNT_ZERO;
               end
            end else begin
               state_d = WAIT_SAV;
            end
         end
         ACTIVE: begin
            if (trs_s) begin
               // line ended early; a new active SAV here cannot be written while padding
               sync_error_d = 1'b1;
               state_d      = PAD;
               if (sav_s && !xy_v_s) begin
                  line_dropped_d = 1'b1;
               end else begin
                  line_dropped_d = 1'b0;
               end
            end else if (y_byte_s) begin
               fifo_write_d = 1'b1;
               fifo_data_d  = s2_q;
               if (count_q == LAST_CNT) begin
                  last_d  = 1'b1;
                  state_d = WAIT_SAV;
               end else begin
                  count_d = count_q + CNT_ONE;
               end
            end else begin
               state_d = ACTIVE;
            end
         end
         PAD: begin
            fifo_write_d = 1'b1;
            fifo_data_d  = PAD_VALUE;
            if (count_q == LAST_CNT) begin
               last_d  = 1'b1;
               state_d = WAIT_SAV;
            end else begin
               count_d = count_q + CNT_ONE;
            end
            if (sav_s && !xy_v_s) begin
               line_dropped_d = 1'b1;
            end else begin
               line_dropped_d = 1'b0;
            end
         end
         DROP: begin
            if (eav_s) begin
               state_d = WAIT_SAV;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = WAIT_SAV;
         end
      endcase
   end

   // Line FSM registers and registered outputs
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_q        <= WAIT_SAV;
         count_q        <= CNT_ZERO;
         fifo_write_q   <= 1'b0;
         fifo_data_q    <= 8'h00;
         last_q         <= 1'b0;
         line_done_q    <= 1'b0;
         line_dropped_q <= 1'b0;
         sync_error_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         fifo_write_q   <= fifo_write_d;
         fifo_data_q    <= fifo_data_d;
         last_q         <= last_d;
         // line_done follows the final write by one cycle
         line_done_q    <= last_q;
         line_dropped_q <= line_dropped_d;
         sync_error_q   <= sync_error_d;
      end
   end

`ifdef BT656_LW_STATS_EN
   logic [15:0] drop_count_q, line_count_q;

   // Saturating statistics counters, cleared only by reset
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         drop_count_q <= 16'h0000;
         line_count_q <= 16'h0000;
      end else begin
         if (line_dropped_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'h0001;
         end
         if (last_q && (line_count_q != 16'hFFFF)) begin
            line_count_q <= line_count_q + 16'h0001;
         end
      end
   end

   assign drop_count = drop_count_q;
   assign line_count = line_count_q;
`endif

   assign fifo_data    = fifo_data_q;
   assign fifo_write   = fifo_write_q;
   assign field        = field_q;
   assign vblank       = vblank_q;
   assign line_done    = line_done_q;
   assign line_dropped = line_dropped_q;
   assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_bt656_line_writer.sv
// -----------------------------------------------------------------------------
// tb_bt656_line_writer
//   Directed bench for bt656_line_writer. Stimulus pushes the expected FIFO
//   write data into a queue; a negedge monitor pops and compares on every
//   fifo_write and counts the pulse outputs.
// -----------------------------------------------------------------------------
module tb_bt656_line_writer;

   logic        clock_in = 1'b0;
   logic        reset    = 1'b1;
   logic [7:0]  bt_data  = 8'h10;
   logic        fifo_full = 1'b0;
   logic [7:0]  fifo_data;
   logic        fifo_write;
   logic        field;
   logic        vblank;
   logic        line_done;
   logic        line_dropped;
   logic        sync_error;
`ifdef BT656_LW_STATS_EN
   logic [15:0] drop_count;
   logic [15:0] line_count;
`endif

   bt656_line_writer dut (
      .clock_in     (clock_in),
      .reset        (reset),
      .bt_data      (bt_data),
      .fifo_full    (fifo_full),
      .fifo_data    (fifo_data),
      .fifo_write   (fifo_write),
      .field        (field),
      .vblank       (vblank),
      .line_done    (line_done),
      .line_dropped (line_dropped),
`ifdef BT656_LW_STATS_EN
      .drop_count   (drop_count),
      .line_count   (line_count),
`endif
      .sync_error   (sync_error)
   );

   always #5 clock_in = ~clock_in;

   int cyc = 0;
   always @(posedge clock_in) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   int n_vec  = 0;
   int n_err  = 0;
   int wr_count = 0, done_count = 0, drop_ev = 0, serr_ev = 0;
   int first_wr_cyc = -1, last_wr_cyc = 0, done_cyc = 0, first_y_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // monitor: scoreboard pop on every write, pulse counting
   always @(negedge clock_in) begin
      if (!reset) begin
         if (fifo_write) begin
            wr_count++;
            last_wr_cyc = cyc;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: actual data 0x%0h, expected no write", fifo_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check("write_data", {24'h0, fifo_data}, {24'h0, e});
            end
         end
         if (line_done) begin
            done_count++;
            done_cyc = cyc;
         end
         if (line_dropped) drop_ev++;
         if (sync_error)   serr_ev++;
      end
   end

   task automatic send(input logic [7:0] b);
      bt_data = b;
      @(posedge clock_in);
      #1;
   endtask

   task automatic send_trs(input logic f, input logic v, input logic h);
      send(8'hFF);
      send(8'h00);
      send(8'h00);
      send({1'b1, f, v, h, 4'b0101});
   endtask

   // one line: SAV, ny Cb/Y pairs (Y ramp from base), EAV, blanking
   task automatic send_line(input logic f, input logic v, input int ny,
                            input logic [7:0] base, input bit push);
      logic [7:0] y;
      send_trs(f, v, 1'b0);
      for (int i = 0; i < ny; i++) begin
         y = base + 8'(i);
         send((i % 2 == 0) ? 8'h80 : 8'h81);
         if (i == 0) first_y_cyc = cyc;
         if (push) exp_q.push_back(y);
         send(y);
      end
      if (push) begin
         for (int i = ny; i < 720; i++) exp_q.push_back(8'h10);
      end
      send_trs(f, v, 1'b1);
      for (int j = 0; j < 16; j++) begin
         send(8'h80);
         send(8'h10);
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clock_in);
      #1;
      check("drain_queue", exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0, d0, e0, p0;

      // reset state
      repeat (3) @(posedge clock_in);
      #1;
      check("rst_fifo_write",   fifo_write,   0);
      check("rst_fifo_data",    fifo_data,    0);
      check("rst_line_done",    line_done,    0);
      check("rst_line_dropped", line_dropped, 0);
      check("rst_sync_error",   sync_error,   0);
      check("rst_field",        field,        0);
      check("rst_vblank",       vblank,       1);
`ifdef BT656_LW_STATS_EN
      check("rst_line_count", line_count, 0);
      check("rst_drop_count", drop_count, 0);
`endif
      reset = 1'b0;
      repeat (4) send(8'h10);

      // 1: full active line with a ramp
      w0 = wr_count; d0 = done_count; e0 = serr_ev; first_wr_cyc = -1;
      send_line(1'b0, 1'b0, 720, 8'h20, 1'b1);
      wait_drain();
      check("t1_writes",          wr_count - w0, 720);
      check("t1_latency",         first_wr_cyc - first_y_cyc, 4);
      check("t1_line_done",       done_count - d0, 1);
      check("t1_done_after_last", done_cyc - last_wr_cyc, 1);
      check("t1_sync_error",      serr_ev - e0, 0);
      check("t1_vblank",          vblank, 0);
      check("t1_field",           field, 0);

      // 2: full FIFO at SAV drops the line, next line is written
      w0 = wr_count; p0 = drop_ev;
      fifo_full = 1'b1;
      send_line(1'b0, 1'b0, 720, 8'h30, 1'b0);
      fifo_full = 1'b0;
      check("t2_drop_writes", wr_count - w0, 0);
      check("t2_dropped",     drop_ev - p0, 1);
      w0 = wr_count;
      send_line(1'b0, 1'b0, 720, 8'h50, 1'b1);
      wait_drain();
      check("t2_next_writes", wr_count - w0, 720);

      // 3: short line of 700 Y, padded to 720
      w0 = wr_count; d0 = done_count; e0 = serr_ev; p0 = drop_ev;
      send_line(1'b0, 1'b0, 700, 8'h40, 1'b1);
      wait_drain();
      check("t3_writes",     wr_count - w0, 720);
      check("t3_sync_error", serr_ev - e0, 1);
      check("t3_line_done",  done_count - d0, 1);
      check("t3_dropped",    drop_ev - p0, 0);

      // 4: vertical blanking line
      w0 = wr_count; e0 = serr_ev;
      send_line(1'b1, 1'b1, 720, 8'h60, 1'b0);
      check("t4_writes",     wr_count - w0, 0);
      check("t4_vblank",     vblank, 1);
      check("t4_field",      field, 1);
      check("t4_sync_error", serr_ev - e0, 0);

      // 5: reset mid-line after 300 writes
      w0 = wr_count;
      send_trs(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         send(8'h80);
         exp_q.push_back(8'(8'h90 + 8'(i)));
         send(8'(8'h90 + 8'(i)));
      end
      send(8'h80); send(8'h55); send(8'h80); send(8'h55); send(8'h80);
      check("t5_writes_before", wr_count - w0, 300);
      check("t5_write_active",  fifo_write, 1);
      reset = 1'b1;
      #1;
      check("t5_write_cleared", fifo_write, 0);
      check("t5_vblank",        vblank, 1);
      check("t5_field",         field, 0);
      check("t5_queue",         exp_q.size(), 0);
`ifdef BT656_LW_STATS_EN
      check("t5_line_count_rst", line_count, 0);
      check("t5_drop_count_rst", drop_count, 0);
`endif
      repeat (2) @(posedge clock_in);
      #1;
      bt_data = 8'h10;
      reset = 1'b0;
      repeat (4) send(8'h10);
      w0 = wr_count;
      send_line(1'b0, 1'b0, 720, 8'h70, 1'b1);
      wait_drain();
      check("t5_after_writes", wr_count - w0, 720);

`ifdef BT656_LW_STATS_EN
      // 6: statistics, 3 completed lines and 2 dropped since reset
      send_line(1'b0, 1'b0, 720, 8'h11, 1'b1);
      send_line(1'b0, 1'b0, 720, 8'h22, 1'b1);
      fifo_full = 1'b1;
      send_line(1'b0, 1'b0, 720, 8'h33, 1'b0);
      send_line(1'b0, 1'b0, 720, 8'h44, 1'b0);
      fifo_full = 1'b0;
      wait_drain();
      check("t6_line_count", line_count, 3);
      check("t6_drop_count", drop_count, 2);
`endif

      repeat (8) send(8'h10);
      check("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
